dp_ram_param: RTL and testbench

DP_RAM_PARAM -- requirements
Module: dp_ram_param

---
 rtl/dp_ram_param.sv | 156 +++++++++++++++
 tb/tb_dp_ram_param.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_param.sv
// Dual-port synchronous RAM with a per-port read latch stage, an optional
// output register stage, selectable same-port read-during-write behaviour
// and a clear sequencer that fills the array with INIT_VALUE after reset.
// Optional collision flag: define DP_RAM_PARAM_COLLISION_DET_EN.
module dp_ram_param #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 9,
  parameter int                    READ_MODE  = 0,  // 0 write-first, 1 read-first, 2 no-change
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  enb,
  input  logic                  wea,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] dinb,
  input  logic                  regcea,
  input  logic                  regceb,
  output logic [DATA_WIDTH-1:0] douta,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  init_busy
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
  ,
  output logic                  collision
`endif
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  // One extra bit so the counter parks at DEPTH instead of wrapping to 0.
  logic [ADDR_WIDTH:0]   clr_cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] lat_a;
  logic [DATA_WIDTH-1:0] lat_b;
  logic                  act_a;
  logic                  act_b;

  // Port traffic is only honoured once the clear sequencer has released the array.
  assign act_a = ena && !init_busy;
  assign act_b = enb && !init_busy;

  // Next latch value for a port that is enabled this cycle.
  function automatic logic [DATA_WIDTH-1:0] lat_next(
    input logic                  we,
    input logic [DATA_WIDTH-1:0] din,
    input logic [DATA_WIDTH-1:0] word,
    input logic [DATA_WIDTH-1:0] cur
  );
    if (!we) return word;
    case (READ_MODE)
      0:       return din;   // write-first: forward the new data
      1:       return word;  // read-first: the word before this write
      default: return cur;   // no-change: keep the previous read
    endcase
  endfunction

  // Sequencer state register and clear address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // register samples the pre-edge values; combinational blocks use blocking.
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Sequencer next state: leave CLEAR on the edge that writes the last address.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (state == ST_CLEAR && clr_cnt == LAST_ADDR) state_nxt = ST_IDLE;
  end

  // Sequencer outputs.
  always_comb begin
    init_busy = (state == ST_CLEAR);
  end

  // Array writes: the sequencer owns the array while clearing; otherwise port A
  // is applied after port B so A wins a same-address double write.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents are defined by the clear sequencer.
    if (init_busy) begin
      mem[clr_cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
    end else begin
      if (enb && web) mem[addrb] <= dinb;
      if (ena && wea) mem[addra] <= dina;
    end
  end

  // Port A read latch; array reads see the pre-edge contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lat_a <= '0;
    else if (act_a) lat_a <= lat_next(wea, dina, mem[addra], lat_a);
  end

  // Port B read latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lat_b <= '0;
    else if (act_b) lat_b <= lat_next(web, dinb, mem[addrb], lat_b);
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] oreg_a;
      logic [DATA_WIDTH-1:0] oreg_b;

      // Port A output stage, advanced by its clock enable.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     oreg_a <= '0;
        else if (regcea && !init_busy) oreg_a <= lat_a;
      end

      // Port B output stage, advanced by its clock enable.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     oreg_b <= '0;
        else if (regceb && !init_busy) oreg_b <= lat_b;
      end

      assign douta = oreg_a;
      assign doutb = oreg_b;
    end else begin : g_no_out_reg
      // Clock enables have no function without the output stage.
      logic unused_regce;
      assign unused_regce = regcea ^ regceb;
      assign douta        = lat_a;
      assign doutb        = lat_b;
    end
  endgenerate

`ifdef DP_RAM_PARAM_COLLISION_DET_EN
  // Registered flag: both ports on the same address with at least one writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= act_a && act_b && (addra == addrb) && (wea || web);
  end
`endif

endmodule

// File: tb/tb_dp_ram_param.sv
// Scoreboard bench for dp_ram_param: four instances (write-first, read-first,
// no-change, write-first with output register) share one stimulus stream.
module tb_dp_ram_param;

  typedef struct {
    logic [8:0] data;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0, enb = 1'b0, wea = 1'b0, web = 1'b0;
  logic [3:0] addra = '0, addrb = '0;
  logic [8:0] dina = '0, dinb = '0;
  logic       regcea = 1'b1, regceb = 1'b1;

  logic [8:0] da0, db0, da1, db1, da2, db2, da3, db3;
  logic       busy0, busy1, busy2, busy3;
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
  logic       coll0, coll1, coll2, coll3;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Streams: 0 u0.A, 1 u0.B, 2 u1.A, 3 u2.A (latency 1); 4 u3.A (latency 2).
  exp_t q0[$], q1[$], q2[$], q3[$], q4[$];
  logic [4:0] issue = '0;
  logic [4:0] p1 = '0;
  logic [4:0] p2 = '0;

  always #5 clk = ~clk;

  dp_ram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(9), .READ_MODE(0), .OUT_REG(0), .INIT_VALUE(9'h1A5)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .regcea(regcea), .regceb(regceb), .douta(da0), .doutb(db0), .init_busy(busy0)
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
    , .collision(coll0)
`endif
  );

  dp_ram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(9), .READ_MODE(1), .OUT_REG(0), .INIT_VALUE(9'h1A5)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .regcea(regcea), .regceb(regceb), .douta(da1), .doutb(db1), .init_busy(busy1)
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
    , .collision(coll1)
`endif
  );

  dp_ram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(9), .READ_MODE(2), .OUT_REG(0), .INIT_VALUE(9'h1A5)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .regcea(regcea), .regceb(regceb), .douta(da2), .doutb(db2), .init_busy(busy2)
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
    , .collision(coll2)
`endif
  );

  dp_ram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(9), .READ_MODE(0), .OUT_REG(1), .INIT_VALUE(9'h1A5)) u3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .regcea(regcea), .regceb(regceb), .douta(da3), .doutb(db3), .init_busy(busy3)
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
    , .collision(coll3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Queue an expected read result for a stream and mark it as issued this cycle.
  task automatic push_exp(input int s, input logic [8:0] d, input string name);
    exp_t e;
    e.data = d;
    e.name = name;
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      default: q4.push_back(e);
    endcase
    issue[s] = 1'b1;
  endtask

  task automatic pop_cmp(input int s, input logic [8:0] act);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (s)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      3: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
      default: if (q4.size() > 0) begin e = q4.pop_front(); have = 1'b1; end
    endcase
    if (have) check(e.name, {23'd0, act}, {23'd0, e.data});
    else begin
      n_total++;
      $display("FAIL stream%0d: no expectation queued, got %0h", s, act);
    end
  endtask

  // Delay line marking when each issued read is due at the outputs.
  always @(posedge clk) begin
    p1 <= issue;
    p2 <= p1;
  end

  // Monitor: compare outputs half a cycle after the edge they are due on.
  always @(negedge clk) begin
    if (p1[0]) pop_cmp(0, da0);
    if (p1[1]) pop_cmp(1, db0);
    if (p1[2]) pop_cmp(2, da1);
    if (p1[3]) pop_cmp(3, da2);
    if (p2[4]) pop_cmp(4, da3);
  end

  task automatic step();
    @(posedge clk);
    #1;
    issue = '0;
    ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
  endtask

  // Release reset just after an edge and count cycles with init_busy high.
  task automatic run_clear(input string tag);
    int n;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (busy0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 8) begin
        check({tag, "_busy_douta0"}, {23'd0, da0}, 32'd0);
        check({tag, "_busy_douta3"}, {23'd0, da3}, 32'd0);
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
        check({tag, "_busy_coll"}, {28'd0, coll0, coll1, coll2, coll3}, 32'd0);
`endif
      end
    end
    check({tag, "_busy_cycles"}, n, 32'd16);
    check({tag, "_busy_low_all"}, {28'd0, busy0, busy1, busy2, busy3}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #2;
    check("rst_busy", {28'd0, busy0, busy1, busy2, busy3}, 32'hF);
    check("rst_dout_u0", {14'd0, da0, db0}, 32'd0);
    check("rst_dout_u1u2", {da1, db1, da2, db2}, 32'd0);
    check("rst_dout_u3", {14'd0, da3, db3}, 32'd0);

    // Port activity during the clear must be ignored.
    ena = 1'b1; wea = 1'b1; addra = 4'd0; dina = 9'h000;
    enb = 1'b1; web = 1'b1; addrb = 4'd0; dinb = 9'h000;
    run_clear("clr1");
    ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;

    // Every address reads INIT_VALUE on both ports.
    for (int i = 0; i < 16; i++) begin
      ena = 1'b1; addra = 4'(i);
      enb = 1'b1; addrb = 4'(15 - i);
      push_exp(0, 9'h1A5, $sformatf("sweep_a%0d", i));
      push_exp(1, 9'h1A5, $sformatf("sweep_b%0d", 15 - i));
      push_exp(2, 9'h1A5, $sformatf("sweep_rf%0d", i));
      push_exp(3, 9'h1A5, $sformatf("sweep_nc%0d", i));
      push_exp(4, 9'h1A5, $sformatf("sweep_or%0d", i));
      step();
    end
    step();

    // Same-port read-during-write in the three modes.
    ena = 1'b1; wea = 1'b1; addra = 4'd5; dina = 9'h011;
    push_exp(0, 9'h011, "wr5a_wf"); push_exp(2, 9'h1A5, "wr5a_rf"); push_exp(3, 9'h1A5, "wr5a_nc");
    step();
    ena = 1'b1; addra = 4'd0;
    push_exp(0, 9'h1A5, "rd0_wf"); push_exp(2, 9'h1A5, "rd0_rf"); push_exp(3, 9'h1A5, "rd0_nc");
    step();
    ena = 1'b1; wea = 1'b1; addra = 4'd5; dina = 9'h0F0;
    push_exp(0, 9'h0F0, "wr5b_wf"); push_exp(2, 9'h011, "wr5b_rf"); push_exp(3, 9'h1A5, "wr5b_nc");
    step();
    ena = 1'b1; addra = 4'd5;
    push_exp(0, 9'h0F0, "rd5_wf"); push_exp(2, 9'h0F0, "rd5_rf"); push_exp(3, 9'h0F0, "rd5_nc");
    step();

    // Both ports write address 3: port A data is stored.
    ena = 1'b1; wea = 1'b1; addra = 4'd3; dina = 9'h0AA;
    enb = 1'b1; web = 1'b1; addrb = 4'd3; dinb = 9'h055;
    push_exp(0, 9'h0AA, "dw3_a"); push_exp(1, 9'h055, "dw3_b");
    push_exp(2, 9'h1A5, "dw3_rf"); push_exp(3, 9'h0F0, "dw3_nc");
    step();
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
    check("coll_dw3", {31'd0, coll0}, 32'd1);
`endif
    ena = 1'b1; addra = 4'd3;
    enb = 1'b1; addrb = 4'd3;
    push_exp(0, 9'h0AA, "rd3_a"); push_exp(1, 9'h0AA, "rd3_b");
    push_exp(2, 9'h0AA, "rd3_rf"); push_exp(3, 9'h0AA, "rd3_nc");
    step();
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
    check("coll_rd3", {31'd0, coll0}, 32'd0);
`endif

    // Cross-port read during write returns the old word.
    ena = 1'b1; wea = 1'b1; addra = 4'd7; dina = 9'h003;
    step();
    ena = 1'b1; wea = 1'b1; addra = 4'd7; dina = 9'h1FF;
    enb = 1'b1; addrb = 4'd7;
    push_exp(1, 9'h003, "xrd7_old"); push_exp(0, 9'h1FF, "xwr7_a");
    step();
`ifdef DP_RAM_PARAM_COLLISION_DET_EN
    check("coll_x7", {31'd0, coll0}, 32'd1);
`endif
    enb = 1'b1; addrb = 4'd7;
    push_exp(1, 9'h1FF, "xrd7_new"); push_exp(0, 9'h1FF, "hold_a_disabled");
    step();

    // Output register stage and its clock enable.
    regcea = 1'b1; ena = 1'b1; addra = 4'd0;
    push_exp(4, 9'h1A5, "or_rd0");
    step();
    step();
    regcea = 1'b0; ena = 1'b1; wea = 1'b1; addra = 4'd2; dina = 9'h042;
    push_exp(4, 9'h1A5, "or_hold1");
    step();
    regcea = 1'b0; ena = 1'b1; addra = 4'd2;
    push_exp(4, 9'h1A5, "or_hold2");
    step();
    regcea = 1'b0;
    push_exp(4, 9'h042, "or_load42");
    step();
    regcea = 1'b1;
    push_exp(4, 9'h042, "or_lat_not_yet");
    step();
    ena = 1'b1; addra = 4'd0;
    push_exp(4, 9'h1A5, "or_lat2");
    step();
    step();
    step();

    // Reset mid-operation: outputs clear at once.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_busy", {28'd0, busy0, busy1, busy2, busy3}, 32'hF);
    check("rst2_dout_u0", {14'd0, da0, db0}, 32'd0);
    check("rst2_dout_u1u2", {da1, db1, da2, db2}, 32'd0);
    check("rst2_dout_u3", {14'd0, da3, db3}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
    end
    check("mid_clear_busy", {31'd0, busy0}, 32'd1);
    // Reset again at clear count 8; the full sequence must restart.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst3_busy", {28'd0, busy0, busy1, busy2, busy3}, 32'hF);
    check("rst3_dout", {14'd0, da0, db0}, 32'd0);
    run_clear("clr3");

    // Previously written addresses are back to INIT_VALUE.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a;
      case (i)
        0: a = 4'd2;
        1: a = 4'd3;
        2: a = 4'd5;
        default: a = 4'd7;
      endcase
      ena = 1'b1; addra = a;
      enb = 1'b1; addrb = a;
      push_exp(0, 9'h1A5, $sformatf("post_a%0d", a));
      push_exp(1, 9'h1A5, $sformatf("post_b%0d", a));
      push_exp(2, 9'h1A5, $sformatf("post_rf%0d", a));
      push_exp(3, 9'h1A5, $sformatf("post_nc%0d", a));
      push_exp(4, 9'h1A5, $sformatf("post_or%0d", a));
      step();
    end
    step();
    step();
    step();

    check("scoreboard_drained", q0.size() + q1.size() + q2.size() + q3.size() + q4.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
